// File: rtl/udp_pkg.sv
// Shared UDP/IPv4/Ethernet framing constants and receive FSM encoding,
// used by both the GMII transmit and receive paths.
package udp_pkg;

  typedef enum logic [2:0] {
    RX_END,
    IDLE,
    PREAMBLE,
    ETH_HEAD,
    IP_HEAD,
    UDP_HEAD,
    RX_DATA
  } rx_state_t;

  localparam logic [15:0] ETH_TYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP    = 8'd17;
  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam logic [15:0] PREAMBLE_LEN    = 16'd7;
  localparam logic [15:0] ETH_HEAD_LEN    = 16'd14;
  localparam logic [15:0] IP_MIN_HEAD_LEN = 16'd20;
  localparam logic [15:0] UDP_HEAD_LEN    = 16'd8;
  localparam logic [47:0] BROADCAST_MAC   = 48'hff_ff_ff_ff_ff_ff;

endpackage

// File: rtl/udp_rx_parser.sv
// GMII receive parser: strips preamble/Ethernet/IPv4/UDP headers, filters on
// board MAC/IP, and delivers the UDP payload as big-endian 32-bit words.
module udp_rx_parser
  import udp_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        rec_en,
  output logic [31:0] rec_data,
  output logic [15:0] rec_byte_num,
  output logic        rec_pkt_done,
  output logic        rec_drop
);

  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] sh;
    sh = mac << {idx, 3'b000};
    return sh[47:40];
  endfunction

  function automatic logic [7:0] ip_byte(input logic [1:0] idx);
    logic [31:0] sh;
    sh = BOARD_IP << {idx, 3'b000};
    return sh[31:24];
  endfunction

  rx_state_t   state, state_n;
  logic [15:0] cnt, cnt_n;
  logic        en_n, done_n, drop_n;
  logic [31:0] word_n, packed_word;
  logic [15:0] num_n;

  logic        first;
  logic        uni_ok, bc_ok, hdr_ok;
  logic        uni_ok_n, bc_ok_n, hdr_ok_n;
  logic [15:0] ip_last;
  logic [7:0]  len_hi;
  logic [15:0] udp_len, pay_len;
  logic [23:0] shift;

  assign first   = (cnt == 16'd0);
  assign pay_len = udp_len - UDP_HEAD_LEN;

  // Partial words are left-aligned: bytes not yet received read as zero.
  always_comb begin
    packed_word = {shift[23:0], gmii_rxd};
    unique case (cnt[1:0])
      2'd0: packed_word = {gmii_rxd, 24'h0};
      2'd1: packed_word = {shift[7:0], gmii_rxd, 16'h0};
      2'd2: packed_word = {shift[15:0], gmii_rxd, 8'h0};
      2'd3: packed_word = {shift[23:0], gmii_rxd};
    endcase
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    en_n     = 1'b0;
    done_n   = 1'b0;
    drop_n   = 1'b0;
    word_n   = rec_data;
    num_n    = rec_byte_num;
    uni_ok_n = uni_ok;
    bc_ok_n  = bc_ok;
    hdr_ok_n = hdr_ok;
    case (state)
      RX_END: if (!gmii_rx_dv) state_n = IDLE;
      IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == PREAMBLE_BYTE) begin
            state_n = PREAMBLE;
            cnt_n   = 16'd1;
          end else begin
            state_n = RX_END;
            drop_n  = 1'b1;
          end
        end
      end
      default: begin
        if (!gmii_rx_dv) begin
          state_n = IDLE;
          drop_n  = 1'b1;
        end else begin
          case (state)
            PREAMBLE: begin
              if (gmii_rxd == PREAMBLE_BYTE && cnt < PREAMBLE_LEN) begin
                cnt_n = cnt + 16'd1;
              end else if (gmii_rxd == SFD_BYTE && cnt == PREAMBLE_LEN) begin
                state_n = ETH_HEAD;
                cnt_n   = 16'd0;
              end else begin
                state_n = RX_END;
                drop_n  = 1'b1;
              end
            end
            ETH_HEAD: begin
              cnt_n = cnt + 16'd1;
              if (cnt < 16'd6) begin
                uni_ok_n = (first | uni_ok) & (gmii_rxd == mac_byte(BOARD_MAC, cnt[2:0]));
                bc_ok_n  = (first | bc_ok) & (gmii_rxd == mac_byte(BROADCAST_MAC, cnt[2:0]));
              end
              if (cnt == 16'd12) hdr_ok_n = (gmii_rxd == ETH_TYPE_IPV4[15:8]);
              if (cnt == ETH_HEAD_LEN - 16'd1) begin
                cnt_n = 16'd0;
                if ((uni_ok | bc_ok) && hdr_ok && gmii_rxd == ETH_TYPE_IPV4[7:0]) begin
                  state_n = IP_HEAD;
                end else begin
                  state_n = RX_END;
                  drop_n  = 1'b1;
                end
              end
            end
            IP_HEAD: begin
              cnt_n    = cnt + 16'd1;
              hdr_ok_n = first | hdr_ok;
              if (first)
                hdr_ok_n = (gmii_rxd[7:4] == 4'd4) && (gmii_rxd[3:0] >= 4'd5);
              if (cnt == 16'd9)
                hdr_ok_n = hdr_ok_n & (gmii_rxd == IP_PROTO_UDP);
              if (cnt >= 16'd16 && cnt <= 16'd19)
                hdr_ok_n = hdr_ok_n & (gmii_rxd == ip_byte(cnt[1:0]));
              // ip_last is loaded while byte 0 is sampled, so byte 0 is never the last.
              if (!first && cnt == ip_last) begin
                cnt_n = 16'd0;
                if (hdr_ok_n) begin
                  state_n = UDP_HEAD;
                end else begin
                  state_n = RX_END;
                  drop_n  = 1'b1;
                end
              end
            end
            UDP_HEAD: begin
              cnt_n = cnt + 16'd1;
              if (cnt == UDP_HEAD_LEN - 16'd1) begin
                cnt_n = 16'd0;
                if (udp_len < UDP_HEAD_LEN) begin
                  state_n = RX_END;
                  drop_n  = 1'b1;
                end else if (udp_len == UDP_HEAD_LEN) begin
                  state_n = RX_END;
                  done_n  = 1'b1;
                  num_n   = 16'd0;
                end else begin
                  state_n = RX_DATA;
                end
              end
            end
            RX_DATA: begin
              cnt_n = cnt + 16'd1;
              if (cnt == pay_len - 16'd1) begin
                state_n = RX_END;
                en_n    = 1'b1;
                word_n  = packed_word;
                done_n  = 1'b1;
                num_n   = pay_len;
              end else if (cnt[1:0] == 2'd3) begin
                en_n   = 1'b1;
                word_n = packed_word;
              end
            end
            default: state_n = RX_END;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RX_END;
      cnt          <= 16'd0;
      rec_en       <= 1'b0;
      rec_data     <= 32'd0;
      rec_byte_num <= 16'd0;
      rec_pkt_done <= 1'b0;
      rec_drop     <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      rec_en       <= en_n;
      rec_data     <= word_n;
      rec_byte_num <= num_n;
      rec_pkt_done <= done_n;
      rec_drop     <= drop_n;
    end
  end

  // Header fields and packing register carry no reset; the FSM qualifies them.
  always_ff @(posedge clk) begin
    uni_ok <= uni_ok_n;
    bc_ok  <= bc_ok_n;
    hdr_ok <= hdr_ok_n;
    if (state == IP_HEAD && first)
      ip_last <= (gmii_rxd[3:0] < 4'd5) ? IP_MIN_HEAD_LEN - 16'd1
                                        : {10'd0, gmii_rxd[3:0], 2'b00} - 16'd1;
    if (state == UDP_HEAD && cnt == 16'd4) len_hi <= gmii_rxd;
    if (state == UDP_HEAD && cnt == 16'd5) udp_len <= {len_hi, gmii_rxd};
    if (state == RX_DATA) shift <= {shift[15:0], gmii_rxd};
  end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Randomized frame-level bench for udp_rx_parser with a byte-array reference
// parser that predicts every output strobe and the cycle it appears in.
module tb_udp_rx_parser;

  localparam logic [47:0] MAC  = 48'h00_11_22_33_44_55;
  localparam logic [31:0] IP   = {8'd192, 8'd168, 8'd1, 8'd10};
  localparam logic [47:0] BCST = 48'hff_ff_ff_ff_ff_ff;

  logic        clk = 1'b0;
  logic        rst;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic        rec_en;
  logic [31:0] rec_data;
  logic [15:0] rec_byte_num;
  logic        rec_pkt_done;
  logic        rec_drop;

  udp_rx_parser dut (
    .clk          (clk),
    .rst          (rst),
    .gmii_rx_dv   (gmii_rx_dv),
    .gmii_rxd     (gmii_rxd),
    .rec_en       (rec_en),
    .rec_data     (rec_data),
    .rec_byte_num (rec_byte_num),
    .rec_pkt_done (rec_pkt_done),
    .rec_drop     (rec_drop)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          cyc;
    bit          en;
    logic [31:0] data;
    bit          done;
    logic [15:0] num;
    bit          drop;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] bget(input bq_t f, input int i);
    return (i < f.size()) ? f[i] : 8'h00;
  endfunction

  function automatic ev_t mk_ev(input int idx);
    ev_t e;
    e = '{cyc: idx, en: 1'b0, data: 32'd0, done: 1'b0, num: 16'd0, drop: 1'b0};
    return e;
  endfunction

  // Reference parser: walks the frame as byte offsets and decides where the
  // frame is accepted, rejected, or cut short by dv falling.
  function automatic void model(input bq_t f, input int base);
    ev_t  evs[$];
    ev_t  e;
    int   dec, ihl, h, p, len, pay, n;
    bit   bad;
    logic [47:0] dmac;
    logic [31:0] dip;
    logic [31:0] w;
    n   = f.size();
    dec = -1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++)
      if (dec < 0 && bget(f, i) != ((i == 7) ? 8'hD5 : 8'h55)) dec = i;
    if (dec >= 0) bad = 1'b1;
    else begin
      dmac = '0;
      for (int i = 8; i < 14; i++) dmac = {dmac[39:0], bget(f, i)};
      if (!((dmac == MAC || dmac == BCST) && bget(f, 20) == 8'h08 && bget(f, 21) == 8'h00)) begin
        dec = 21; bad = 1'b1;
      end else begin
        ihl = int'(bget(f, 22) & 8'h0f);
        h   = (ihl >= 5) ? ihl * 4 : 20;
        dip = '0;
        for (int i = 38; i < 42; i++) dip = {dip[23:0], bget(f, i)};
        if (!((bget(f, 22) >> 4) == 8'd4 && ihl >= 5 && bget(f, 31) == 8'd17 && dip == IP)) begin
          dec = 22 + h - 1; bad = 1'b1;
        end else begin
          len = int'({bget(f, 22 + h + 4), bget(f, 22 + h + 5)});
          p   = 22 + h + 8;
          if (len < 8) begin
            dec = p - 1; bad = 1'b1;
          end else if (len == 8) begin
            dec = p - 1;
            e = mk_ev(dec); e.done = 1'b1; e.num = 16'd0;
            evs.push_back(e);
          end else begin
            pay = len - 8;
            dec = p + pay - 1;
            for (int j = 0; j < pay; j++) begin
              if (j % 4 == 3 || j == pay - 1) begin
                w = 32'd0;
                for (int k = 0; k <= j % 4; k++) w[31 - 8 * k -: 8] = bget(f, p + j - j % 4 + k);
                e = mk_ev(p + j); e.en = 1'b1; e.data = w;
                if (j == pay - 1) begin e.done = 1'b1; e.num = 16'(pay); end
                evs.push_back(e);
              end
            end
          end
        end
      end
    end
    if (bad) begin
      e = mk_ev(dec); e.drop = 1'b1;
      evs.push_back(e);
    end
    if (dec >= n) begin
      while (evs.size() > 0 && evs[evs.size() - 1].cyc >= n) void'(evs.pop_back());
      e = mk_ev(n); e.drop = 1'b1;
      evs.push_back(e);
    end
    foreach (evs[i]) begin
      e = evs[i];
      e.cyc = base + 1 + e.cyc;
      exp_q.push_back(e);
    end
  endfunction

  function automatic bq_t build(input logic [47:0] dmac, input logic [15:0] etype,
                                input logic [7:0] vihl, input logic [7:0] proto,
                                input logic [31:0] dip, input logic [15:0] ulen,
                                input bq_t pay, input int fcs);
    bq_t f;
    int  opts;
    for (int i = 0; i < 7; i++) f.push_back(8'h55);
    f.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) f.push_back(dmac[8 * i +: 8]);
    for (int i = 0; i < 6; i++) f.push_back(8'($urandom));
    f.push_back(etype[15:8]); f.push_back(etype[7:0]);
    f.push_back(vihl); f.push_back(8'h00);
    f.push_back(8'h00); f.push_back(8'(28 + pay.size()));
    for (int i = 0; i < 4; i++) f.push_back(8'($urandom));
    f.push_back(8'd64); f.push_back(proto);
    f.push_back(8'h00); f.push_back(8'h00);
    f.push_back(8'd192); f.push_back(8'd168); f.push_back(8'd1); f.push_back(8'd2);
    for (int i = 3; i >= 0; i--) f.push_back(dip[8 * i +: 8]);
    opts = (int'(vihl[3:0]) > 5) ? (int'(vihl[3:0]) - 5) * 4 : 0;
    for (int i = 0; i < opts; i++) f.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) f.push_back(8'($urandom));
    f.push_back(ulen[15:8]); f.push_back(ulen[7:0]);
    f.push_back(8'h00); f.push_back(8'h00);
    foreach (pay[i]) f.push_back(pay[i]);
    for (int i = 0; i < fcs; i++) f.push_back(8'($urandom));
    return f;
  endfunction

  task automatic send_frame(input bq_t f, input int gap);
    @(negedge clk);
    model(f, cyc);
    foreach (f[i]) begin
      if (i > 0) @(negedge clk);
      gmii_rx_dv = 1'b1;
      gmii_rxd   = f[i];
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      gmii_rx_dv = 1'b0;
      gmii_rxd   = 8'($urandom);
    end
  endtask

  ev_t mon_e;
  bit  mon_have;
  always @(negedge clk) begin
    mon_e    = mk_ev(0);
    mon_have = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e    = exp_q.pop_front();
      mon_have = 1'b1;
    end
    if (mon_have || rec_en || rec_pkt_done || rec_drop) begin
      check_eq("rec_en", rec_en, mon_e.en);
      check_eq("rec_pkt_done", rec_pkt_done, mon_e.done);
      check_eq("rec_drop", rec_drop, mon_e.drop);
      if (mon_e.en)   check_eq("rec_data", rec_data, mon_e.data);
      if (mon_e.done) check_eq("rec_byte_num", rec_byte_num, mon_e.num);
    end
  end

  bq_t p6, p4, p5, pn, f;
  int  kind, plen, ulen, ihl;
  logic [47:0] dmac;
  logic [31:0] dip;
  logic [7:0]  proto;
  logic [15:0] etype;

  initial begin
    rst = 1'b1; gmii_rx_dv = 1'b0; gmii_rxd = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_en", rec_en, 0);
    check_eq("rst_data", rec_data, 0);
    check_eq("rst_num", rec_byte_num, 0);
    check_eq("rst_done", rec_pkt_done, 0);
    check_eq("rst_drop", rec_drop, 0);
    rst = 1'b0;
    @(negedge clk);

    p6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    p4 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    p5 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    pn = '{};
    send_frame(build(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'd14, p6, 4), 1);
    repeat (3) @(negedge clk);
    check_eq("byte_num_hold", rec_byte_num, 6);
    send_frame(build(BCST, 16'h0800, 8'h45, 8'd17, IP, 16'd14, p6, 4), 1);
    send_frame(build(48'h00_11_22_33_44_56, 16'h0800, 8'h45, 8'd17, IP, 16'd14, p6, 4), 1);
    send_frame(build(MAC, 16'h0800, 8'h46, 8'd17, IP, 16'd12, p4, 4), 1);
    send_frame(build(MAC, 16'h0800, 8'h45, 8'd6, IP, 16'd14, p6, 4), 1);
    send_frame(build(MAC, 16'h0800, 8'h45, 8'd17, {8'd192, 8'd168, 8'd1, 8'd11}, 16'd14, p6, 4), 1);
    send_frame(build(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'd14, p6, 4), 2);
    send_frame(build(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'd8, pn, 4), 1);
    send_frame(build(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'd20, p5, 0), 1);
    send_frame(build(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'd7, pn, 4), 1);
    send_frame(build(MAC, 16'h0806, 8'h45, 8'd17, IP, 16'd14, p6, 4), 1);
    f = build(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'd14, p6, 4);
    f[3] = 8'h54;
    send_frame(f, 1);
    f = build(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'd14, p6, 4);
    f[6] = 8'hD5;
    send_frame(f, 1);

    // Reset pulsed mid-payload with dv held high: nothing from this frame.
    f = build(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'd16, '{1, 2, 3, 4, 5, 6, 7, 8}, 4);
    @(negedge clk);
    for (int i = 0; i < f.size(); i++) begin
      if (i > 0) @(negedge clk);
      gmii_rx_dv = 1'b1;
      gmii_rxd   = f[i];
      if (i == 51) begin
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_en", rec_en, 0);
        check_eq("midrst_data", rec_data, 0);
        check_eq("midrst_num", rec_byte_num, 0);
        check_eq("midrst_done", rec_pkt_done, 0);
        check_eq("midrst_drop", rec_drop, 0);
      end
      if (i == 52) #2 rst = 1'b0;
    end
    @(negedge clk);
    gmii_rx_dv = 1'b0;
    send_frame(build(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'd14, p6, 4), 1);

    for (int r = 0; r < 50; r++) begin
      kind  = $urandom_range(0, 9);
      plen  = $urandom_range(0, 24);
      ihl   = $urandom_range(5, 7);
      dmac  = ($urandom_range(0, 1) == 0) ? MAC : BCST;
      dip   = IP;
      proto = 8'd17;
      etype = 16'h0800;
      ulen  = plen + 8;
      pn    = '{};
      for (int i = 0; i < plen; i++) pn.push_back(8'($urandom));
      case (kind)
        0: dmac  = {16'h0011, 32'($urandom)};
        1: proto = 8'($urandom_range(0, 16));
        2: dip   = IP ^ (32'd1 << $urandom_range(0, 31));
        3: etype = 16'h86DD;
        4: ulen  = $urandom_range(0, 7);
        5: if (plen > 0) pn = pn[0:$urandom_range(0, plen - 1)];
        6: ihl   = $urandom_range(0, 4);
        default: ;
      endcase
      f = build(dmac, etype, {4'd4, 4'(ihl)}, proto, dip, 16'(ulen), pn, (kind == 5) ? 0 : 4);
      if (kind == 7) f[$urandom_range(0, 7)] = 8'($urandom_range(0, 255));
      send_frame(f, $urandom_range(1, 3));
    end

    repeat (5) @(negedge clk);
    check_eq("events_outstanding", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_rx_parser.md
# udp_rx_parser

Receive-side counterpart of the UDP/GMII transmit path. Parses GMII byte frames (preamble, Ethernet II, IPv4, UDP), filters on board MAC/IP and UDP protocol, and delivers the UDP payload as big-endian 32-bit words with a byte count and packet-done strobe. Sits between the PHY GMII receive pins and the user receive interface, clocked by the GMII receive clock. FCS is not checked; the four trailing FCS bytes are discarded.

## Interface

- BOARD_MAC, 48'h00_11_22_33_44_55, unicast MAC accepted (broadcast ff_ff_ff_ff_ff_ff is also accepted)
- BOARD_IP, {8'd192,8'd168,8'd1,8'd10}, IPv4 destination accepted

- clk  input  1  GMII receive clock; one clock, all logic on its rising edge
- rst  input  1  asynchronous, active-high reset
- gmii_rx_dv  input  1  GMII receive data valid
- gmii_rxd  input  8  GMII receive byte
- rec_en  output  1  one-cycle strobe: rec_data holds a payload word
- rec_data  output  32  payload word; first byte received in [31:24]
- rec_byte_num  output  16  payload byte count (UDP length − 8); valid when rec_pkt_done=1, held until next frame's done
- rec_pkt_done  output  1  one-cycle strobe: frame payload complete
- rec_drop  output  1  one-cycle strobe: frame rejected or truncated

## Operation

- States: RX_END, IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, UDP_HEAD, RX_DATA. Reset state RX_END.
- RX_END: wait for gmii_rx_dv=0, then IDLE. Guarantees no mid-frame lock-on after reset.
- IDLE: dv=1 and rxd=0x55 → PREAMBLE (count 1); dv=1 with other byte → RX_END, rec_drop.
- PREAMBLE: exactly 7 × 0x55 then 0xD5 → ETH_HEAD; any deviation → RX_END, rec_drop.
- ETH_HEAD (14 bytes): bytes 0–5 must equal BOARD_MAC or all-ones; bytes 12–13 must be 0x0800. Checked at byte 13; mismatch → RX_END, rec_drop.
- IP_HEAD: byte 0 high nibble must be 4; low nibble IHL ≥ 5, header length IHL×4 bytes. Byte 9 must be 17. Bytes 16–19 must equal BOARD_IP. Bytes 20..IHL×4−1 (options) skipped. Checked at last header byte; failure → RX_END, rec_drop.
- UDP_HEAD (8 bytes): bytes 4–5 = UDP length L (16 bits). Payload N = L−8; L < 8 → drop. N=0 → pulse rec_pkt_done with rec_byte_num=0, no rec_en, → RX_END.
- RX_DATA: bytes packed MSB-first into 32-bit shift register; rec_en pulses after every 4th byte. On last payload byte, any partial word is emitted left-aligned, unused low bytes zero, with rec_en and rec_pkt_done in the same cycle; rec_byte_num=N. Then → RX_END (FCS/padding ignored).
- gmii_rx_dv falling in any state other than IDLE/RX_END → IDLE directly, rec_drop pulse, no rec_pkt_done; words already emitted are not retracted.
- Byte/header counters 16-bit; payload counter compares against N, never wraps for N ≤ 65527.

## Timing

- All outputs registered; reset values: rec_en=0, rec_data=0, rec_byte_num=0, rec_pkt_done=0, rec_drop=0.
- rec_en asserted the cycle after the 4th byte of a word is sampled.
- rec_pkt_done/final rec_en asserted the cycle after the last payload byte is sampled.
- rec_drop asserted the cycle after the offending byte (or dv low) is sampled.
- rec_en, rec_pkt_done, rec_drop each exactly one cycle; rec_drop never coincides with rec_pkt_done.
- Minimum inter-frame gap: one cycle of dv=0.
- rst asserted mid-frame: outputs clear immediately; remainder of frame ignored (RX_END).

## Structure

- Shared package udp_pkg: state encoding, ETH_TYPE_IPV4=16'h0800, IP_PROTO_UDP=8'd17, PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, ETH_HEAD_LEN=14, UDP_HEAD_LEN=8, BROADCAST_MAC. Transmit side uses the same constants.
- No sub-module: single FSM plus byte counter and packing register.

## Test plan

- Frame to 00-11-22-33-44-55 / 192.168.1.10, UDP length 14, payload 11 22 33 44 55 66 → rec_en 0x11223344, then rec_en 0x55660000 with rec_pkt_done, rec_byte_num=6; no rec_drop.
- Same frame to MAC ff-ff-ff-ff-ff-ff → identical output; to 00-11-22-33-44-56 → rec_drop, no rec_en.
- IHL=6 (4 option bytes), payload DE AD BE EF → single rec_en 0xDEADBEEF with rec_pkt_done, rec_byte_num=4.
- Protocol 6 (TCP) or dest IP 192.168.1.11 → rec_drop after IP header, no rec_en; next valid frame received normally.
- UDP length 8 → rec_pkt_done, rec_byte_num=0, no rec_en; length 20 with dv dropped after 5 payload bytes → one rec_en, then rec_drop, no rec_pkt_done.
- rst pulsed mid-payload, dv kept high → all outputs 0, nothing emitted for that frame; next frame after dv=0 received correctly.
